accumulate_rr_scheduler: RTL and testbench

// - Round-robin scheduler sharing one 0..99 decimal accumulator among NREQ requesters.
// - Grants one valid/ready transfer at a time and adds the accepted word to the running sum.
// - Converts the sum to two BCD digits by iterative subtraction, for the downstream 7-segment decoder.
// - Sits between the input sources and the two-digit display LUT.

---
 rtl/accumulate_rr_scheduler_if.sv | 26 ++
 rtl/accumulate_rr_scheduler.sv | 152 +++++++++++++++
 tb/tb_accumulate_rr_scheduler.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accumulate_rr_scheduler_if.sv
// rtl/accumulate_rr_scheduler_if.sv - requester/display bundle for the round-robin accumulator
interface accumulate_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 3
);
  logic [NREQ-1:0]   s_valid;
  logic [NREQ*W-1:0] s_data;
  logic [NREQ-1:0]   s_ready;
  logic [3:0]        tens;
  logic [3:0]        ones;
  logic              m_valid;
  logic              wrap;
  logic              busy;

  // Source side: requesters plus the display consumer
  modport master (
    output s_valid, s_data,
    input  s_ready, tens, ones, m_valid, wrap, busy
  );

  // Scheduler side
  modport slave (
    input  s_valid, s_data,
    output s_ready, tens, ones, m_valid, wrap, busy
  );
endinterface

// File: rtl/accumulate_rr_scheduler.sv
// rtl/accumulate_rr_scheduler.sv - round-robin shared 0..MAXV accumulator with BCD output; option macro ACC_SATURATE_EN
module accumulate_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 3,
  parameter int MAXV = 99
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clr,
  accumulate_rr_scheduler_if.slave    bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ACC, CONV} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [W-1:0]    data_q;
  logic [6:0]      sum;
  logic [6:0]      work;
  logic [3:0]      tcnt;
  logic [3:0]      tens_q;
  logic [3:0]      ones_q;
  logic            m_valid_q;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gidx;
  logic [W-1:0]    data_sel;
  logic [PW-1:0]   ptr_inc;
  logic            xfer;
  logic [7:0]      nxt;
  logic            over;
  logic [6:0]      sum_new;

  // Round-robin search starting at ptr; first valid requester wins
  always_comb begin
    grant = '0;
    gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int            j;
      logic [PW-1:0] jj;
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = PW'(j);
      if (grant == '0 && bus.s_valid[jj]) begin
        grant[jj] = 1'b1;
        gidx      = jj;
      end
    end
  end

  // Data of the granted requester; other lanes are ignored
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) data_sel = bus.s_data[i*W +: W];
    end
  end

  // Pointer advance past the winner and the accumulate arithmetic
  always_comb begin
    ptr_inc = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    xfer    = |(bus.s_valid & bus.s_ready);
    nxt     = 8'(sum) + 8'(data_q);
    over    = nxt > 8'(MAXV);
`ifdef ACC_SATURATE_EN
    sum_new = over ? 7'(MAXV) : nxt[6:0];
`else
    sum_new = over ? 7'd0 : nxt[6:0];
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: clear aborts anything back to IDLE
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (xfer) state_nxt = ACC;
        ACC:     state_nxt = CONV;
        CONV:    if (work < 7'd10) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: grant only while idle, wrap during the overflowing ACC cycle
  always_comb begin
    bus.s_ready = (state == IDLE && rstn && !clr) ? grant : '0;
    bus.busy    = (state == ACC) || (state == CONV);
    bus.wrap    = (state == ACC) && rstn && !clr && over;
  end

  // Datapath: latch word, update sum, subtract-by-ten conversion
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr       <= '0;
      data_q    <= '0;
      sum       <= '0;
      work      <= '0;
      tcnt      <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      m_valid_q <= 1'b0;
    end else begin
      m_valid_q <= 1'b0;
      if (clr) begin
        sum    <= '0;
        tens_q <= '0;
        ones_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (xfer) begin
              data_q <= data_sel;
              ptr    <= ptr_inc;
            end
          end
          ACC: begin
            sum  <= sum_new;
            work <= sum_new;
            tcnt <= '0;
          end
          CONV: begin
            if (work >= 7'd10) begin
              work <= work - 7'd10;
              tcnt <= tcnt + 4'd1;
            end else begin
              tens_q    <= tcnt;
              ones_q    <= work[3:0];
              m_valid_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.tens    = tens_q;
  assign bus.ones    = ones_q;
  assign bus.m_valid = m_valid_q;

endmodule

// File: tb/tb_accumulate_rr_scheduler.sv
// tb/tb_accumulate_rr_scheduler.sv - self-checking bench with timeline model for accumulate_rr_scheduler
module tb_accumulate_rr_scheduler;

  localparam int N    = 4;
  localparam int W    = 3;
  localparam int MAXV = 99;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic clr  = 1'b0;

  accumulate_rr_scheduler_if #(.NREQ(N), .W(W)) bif ();

  accumulate_rr_scheduler #(.NREQ(N), .W(W), .MAXV(MAXV)) dut (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Timeline model: the scheduler is free from cycle free_at, a result
  // appears at mv_at, an overflow is flagged at wrap_at.
  int cyc      = 0;
  bit model_ok = 0;
  int m_sum    = 0;
  int m_ptr    = 0;
  int free_at  = 0;
  int mv_at    = -1;
  int wrap_at  = -1;
  int pend_t   = 0;
  int pend_o   = 0;
  int disp_t   = 0;
  int disp_o   = 0;

  // Event log taken from the DUT for the directed literal checks
  int hs_cnt = 0, mv_cnt = 0, wrap_cnt = 0, busy_cnt = 0;
  int last_hs_cyc = 0, last_mv_cyc = 0, last_t = 0, last_o = 0;
  int grant_log[$];
  int sum_log[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: cycle budget expired at cycle %0d", name, cyc);
  endtask

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Compare the current cycle against the model, then advance the model
  task automatic check_cycle();
    logic [N-1:0] er;
    int g, d, nx, k;
    bit idle;
    idle = (cyc >= free_at);
    g    = pick(m_ptr, bif.s_valid);
    er   = '0;
    if (idle && rstn && !clr && g >= 0) er[g] = 1'b1;
    chk("s_ready", int'(bif.s_ready), int'(er));
    if (model_ok) begin
      if (cyc == mv_at) begin
        disp_t = pend_t;
        disp_o = pend_o;
      end
      chk("busy",    int'(bif.busy),    int'(!idle));
      chk("wrap",    int'(bif.wrap),    int'((cyc == wrap_at) && rstn && !clr));
      chk("m_valid", int'(bif.m_valid), int'(cyc == mv_at));
      chk("tens",    int'(bif.tens),    disp_t);
      chk("ones",    int'(bif.ones),    disp_o);
    end

    if ((bif.s_valid & bif.s_ready) != '0) begin
      hs_cnt++;
      last_hs_cyc = cyc;
      for (int i = 0; i < N; i++) if (bif.s_ready[i]) grant_log.push_back(i);
    end
    if (bif.m_valid) begin
      mv_cnt++;
      last_mv_cyc = cyc;
      last_t = int'(bif.tens);
      last_o = int'(bif.ones);
      sum_log.push_back(last_t * 10 + last_o);
    end
    if (bif.wrap) wrap_cnt++;
    if (bif.busy) busy_cnt++;

    if (!rstn) begin
      model_ok = 1;
      m_sum = 0; m_ptr = 0; free_at = cyc + 1;
      mv_at = -1; wrap_at = -1; disp_t = 0; disp_o = 0;
    end else if (clr) begin
      m_sum = 0; free_at = cyc + 1;
      mv_at = -1; wrap_at = -1; disp_t = 0; disp_o = 0;
    end else if (er != '0) begin
      d  = int'(bif.s_data[g*W +: W]);
      nx = m_sum + d;
      wrap_at = (nx > MAXV) ? cyc + 1 : -1;
`ifdef ACC_SATURATE_EN
      m_sum = (nx > MAXV) ? MAXV : nx;
`else
      m_sum = (nx > MAXV) ? 0 : nx;
`endif
      k       = m_sum / 10;
      mv_at   = cyc + 3 + k;
      free_at = cyc + 3 + k;
      pend_t  = m_sum / 10;
      pend_o  = m_sum % 10;
      m_ptr   = (g + 1) % N;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input int d);
    bif.s_data[idx*W +: W] = W'(d);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clr  = 1'b0;
    bif.s_valid = '1;
    step();
    step();
    bif.s_valid = '0;
    rstn = 1'b1;
  endtask

  task automatic wait_hs(input int h0);
    int n;
    n = 0;
    while (hs_cnt == h0 && n < 40) begin step(); n++; end
    if (hs_cnt == h0) timeout("handshake_wait");
  endtask

  task automatic wait_mv(input int m0);
    int n;
    n = 0;
    while (mv_cnt == m0 && n < 40) begin step(); n++; end
    if (mv_cnt == m0) timeout("m_valid_wait");
  endtask

  // One transfer from requester idx, run through to its m_valid
  task automatic do_add(input int idx, input int d, output int lat);
    int h0, m0;
    set_data(idx, d);
    bif.s_valid = N'(1) << idx;
    h0 = hs_cnt;
    m0 = mv_cnt;
    wait_hs(h0);
    bif.s_valid = '0;
    wait_mv(m0);
    lat = last_mv_cyc - last_hs_cyc;
  endtask

  int lat, b0, w0, h0, m0, n;
  int exp_g[5]    = '{0, 1, 2, 3, 0};
  int exp_sums[5] = '{1, 3, 6, 10, 11};

  initial begin
    bif.s_valid = '0;
    bif.s_data  = '0;
    #1;

    // Reset with every requester asking
    do_reset();
    step();
    chk("reset_tens", int'(bif.tens), 0);
    chk("reset_ones", int'(bif.ones), 0);
    chk("reset_mvalid", int'(bif.m_valid), 0);

    // Single add
    b0 = busy_cnt;
    do_add(0, 7, lat);
    chk("single_latency", lat, 3);
    chk("single_tens", last_t, 0);
    chk("single_ones", last_o, 7);
    chk("single_busy_cycles", busy_cnt - b0, 2);

    // Round robin with all requesters valid
    do_reset();
    for (int i = 0; i < N; i++) set_data(i, i + 1);
    grant_log.delete();
    sum_log.delete();
    h0 = hs_cnt;
    m0 = mv_cnt;
    bif.s_valid = '1;
    n = 0;
    while (hs_cnt - h0 < 5 && n < 80) begin step(); n++; end
    if (hs_cnt - h0 < 5) timeout("rr_grants");
    bif.s_valid = '0;
    n = 0;
    while (mv_cnt - m0 < 5 && n < 40) begin step(); n++; end
    if (mv_cnt - m0 < 5) timeout("rr_results");
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", (i < grant_log.size()) ? grant_log[i] : -1, exp_g[i]);
      chk("rr_sum", (i < sum_log.size()) ? sum_log[i] : -1, exp_sums[i]);
    end

    // Build sum 90, then +7 exercises the longest conversion
    do_reset();
    for (int i = 0; i < 12; i++) do_add(i % N, 7, lat);
    do_add(1, 6, lat);
    chk("sum90_tens", last_t, 9);
    chk("sum90_ones", last_o, 0);
    do_add(2, 7, lat);
    chk("conv_latency", lat, 12);
    chk("conv_tens", last_t, 9);
    chk("conv_ones", last_o, 7);

    // Overflow: 97 + 5
    w0 = wrap_cnt;
    do_add(3, 5, lat);
    chk("wrap_pulses", wrap_cnt - w0, 1);
`ifdef ACC_SATURATE_EN
    chk("ovf_tens", last_t, 9);
    chk("ovf_ones", last_o, 9);
`else
    chk("ovf_tens", last_t, 0);
    chk("ovf_ones", last_o, 0);
`endif

    // Clear in the middle of a conversion
    do_reset();
    do_add(0, 7, lat);
    do_add(0, 7, lat);
    set_data(1, 7);
    bif.s_valid = 4'b0010;
    h0 = hs_cnt;
    wait_hs(h0);
    bif.s_valid = '0;
    step();
    m0 = mv_cnt;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("clr_no_mvalid", mv_cnt - m0, 0);
    chk("clr_tens", int'(bif.tens), 0);
    chk("clr_ones", int'(bif.ones), 0);
    for (int i = 0; i < N; i++) set_data(i, 5);
    set_data(2, 3);
    grant_log.delete();
    bif.s_valid = '1;
    h0 = hs_cnt;
    m0 = mv_cnt;
    wait_hs(h0);
    bif.s_valid = '0;
    wait_mv(m0);
    chk("clr_next_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 2);
    chk("clr_restart_tens", last_t, 0);
    chk("clr_restart_ones", last_o, 3);

    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
